// File: rtl/rob_issue_queue_buffer_pkg.sv
// Shared parameters and types for the ROB-to-issue in-order buffer.
// Imported by the interface, the age comparator and the buffer itself.
package rob_issue_queue_buffer_pkg;

  localparam int DEF_DATA_WIDTH     = 128;
  localparam int DEF_ROB_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH          = 4;

  // A flush outranks a kill, which outranks the ordinary push/pop update.
  typedef enum logic [1:0] {
    UPD_NORMAL,
    UPD_KILL,
    UPD_FLUSH
  } upd_mode_e;

  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rob_issue_queue_buffer_if.sv
// Handshake and control bundle between the allocate stage, the buffer and
// the issue stage. The buffer takes the slave side.
interface rob_issue_queue_buffer_if
  import rob_issue_queue_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ROB_ADDR_WIDTH = DEF_ROB_ADDR_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CNT_WIDTH      = cntWidth(DEPTH)
) ();

  logic                      flush;
  logic                      kill_valid;
  logic [ROB_ADDR_WIDTH-1:0] kill_rob_addr;
  logic [ROB_ADDR_WIDTH-1:0] rob_head;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROB_ADDR_WIDTH-1:0] in_rob_addr;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ROB_ADDR_WIDTH-1:0] out_rob_addr;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0]      count;

  modport master (
    output flush, kill_valid, kill_rob_addr, rob_head,
    output in_valid, in_rob_addr, in_data, out_ready,
    input  in_ready, out_valid, out_rob_addr, out_data, count
  );

  modport slave (
    input  flush, kill_valid, kill_rob_addr, rob_head,
    input  in_valid, in_rob_addr, in_data, out_ready,
    output in_ready, out_valid, out_rob_addr, out_data, count
  );

endinterface

// File: rtl/rob_issue_queue_buffer_age_cmp.sv
// Decides whether a ROB tag survives a branch kill: it survives when its age
// relative to the commit pointer does not exceed the branch's age.
module rob_age_cmp
  import rob_issue_queue_buffer_pkg::*;
#(
  parameter int ROB_ADDR_WIDTH = DEF_ROB_ADDR_WIDTH
) (
  input  logic [ROB_ADDR_WIDTH-1:0] tag_i,
  input  logic [ROB_ADDR_WIDTH-1:0] rob_head_i,
  input  logic [ROB_ADDR_WIDTH-1:0] kill_rob_addr_i,
  output logic                      survive_o
);

  logic [ROB_ADDR_WIDTH-1:0] tagAge;
  logic [ROB_ADDR_WIDTH-1:0] killAge;

  // Modular subtraction makes ROB-tag wrap-around transparent.
  assign tagAge    = tag_i - rob_head_i;
  assign killAge   = kill_rob_addr_i - rob_head_i;
  assign survive_o = (tagAge <= killAge);

endmodule

// File: rtl/rob_issue_queue_buffer.sv
// DEPTH-entry in-order buffer between ROB allocate and issue, with full flush
// and selective squash of entries younger than a mispredicted branch.
module rob_issue_queue_buffer
  import rob_issue_queue_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ROB_ADDR_WIDTH = DEF_ROB_ADDR_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CNT_WIDTH      = cntWidth(DEPTH)
) (
  input logic                     clk,
  input logic                     rst,
  rob_issue_queue_buffer_if.slave bus
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [PTR_W-1:0]          headPtr_q, headPtr_d;
  logic [PTR_W-1:0]          tailPtr_q, tailPtr_d;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0]     dataMem_q [DEPTH];
  logic [ROB_ADDR_WIDTH-1:0] tagMem_q  [DEPTH];

  logic                      outValid, inReady, push, pop, popEff;
  logic                      wrEn;
  logic [PTR_W-1:0]          wrIdx, scanIdx;
  logic [DEPTH-1:0]          entrySurvive;
  logic                      inSurvive, alive;
  logic [CNT_WIDTH-1:0]      survCnt, remain;
  upd_mode_e                 mode;

  // in_ready looks only at registered occupancy, so a full buffer cannot
  // accept a push even when the head is leaving in the same cycle.
  assign outValid = (count_q != '0);
  assign inReady  = (count_q != FULL_CNT);
  assign push     = bus.in_valid & inReady;
  assign pop      = outValid & bus.out_ready;

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = outValid;
  assign bus.out_rob_addr = outValid ? tagMem_q[headPtr_q]  : '0;
  assign bus.out_data     = outValid ? dataMem_q[headPtr_q] : '0;
  assign bus.count        = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entryCmp
    rob_age_cmp #(.ROB_ADDR_WIDTH(ROB_ADDR_WIDTH)) u_cmp (
      .tag_i           (tagMem_q[i]),
      .rob_head_i      (bus.rob_head),
      .kill_rob_addr_i (bus.kill_rob_addr),
      .survive_o       (entrySurvive[i])
    );
  end

  rob_age_cmp #(.ROB_ADDR_WIDTH(ROB_ADDR_WIDTH)) u_inCmp (
    .tag_i           (bus.in_rob_addr),
    .rob_head_i      (bus.rob_head),
    .kill_rob_addr_i (bus.kill_rob_addr),
    .survive_o       (inSurvive)
  );

  // Survivors form a prefix from head; count them until the first casualty.
  always_comb begin
    survCnt = '0;
    alive   = 1'b1;
    scanIdx = headPtr_q;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = headPtr_q + PTR_W'(k);
      if (alive && (CNT_WIDTH'(k) < count_q) && entrySurvive[scanIdx]) begin
        survCnt = survCnt + CNT_WIDTH'(1);
      end else begin
        alive = 1'b0;
      end
    end
  end

  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    wrIdx     = tailPtr_q;
    wrEn      = 1'b0;
    popEff    = pop;
    remain    = survCnt;
    if (bus.flush) begin
      mode = UPD_FLUSH;
    end else if (bus.kill_valid) begin
      mode = UPD_KILL;
    end else begin
      mode = UPD_NORMAL;
    end
    case (mode)
      UPD_FLUSH: begin
        headPtr_d = '0;
        tailPtr_d = '0;
        count_d   = '0;
      end
      UPD_KILL: begin
        // The tail collapses onto the end of the surviving prefix.
        popEff    = pop && (survCnt != '0);
        remain    = survCnt - CNT_WIDTH'(popEff);
        wrEn      = push && inSurvive;
        wrIdx     = headPtr_q + survCnt[PTR_W-1:0];
        headPtr_d = headPtr_q + PTR_W'(popEff);
        tailPtr_d = wrIdx + PTR_W'(wrEn);
        count_d   = remain + CNT_WIDTH'(wrEn);
      end
      default: begin
        wrEn      = push;
        headPtr_d = headPtr_q + PTR_W'(pop);
        tailPtr_d = tailPtr_q + PTR_W'(push);
        count_d   = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage is left unreset; the output mux hides stale contents when empty.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      dataMem_q[wrIdx] <= bus.in_data;
      tagMem_q[wrIdx]  <= bus.in_rob_addr;
    end
  end

endmodule

// File: tb/tb_rob_issue_queue_buffer.sv
// Directed vector bench for rob_issue_queue_buffer: a table of per-cycle
// stimulus with expected post-edge state, plus async-reset and latency sequences.
module tb_rob_issue_queue_buffer;
  import rob_issue_queue_buffer_pkg::*;

  typedef struct {
    string      name;
    logic       flush;
    logic       kill;
    logic [3:0] killAddr;
    logic [3:0] robHead;
    logic       inValid;
    logic [3:0] inTag;
    logic       outReady;
    logic       expValid;
    logic [3:0] expTag;
    logic [2:0] expCount;
    logic       expReady;
  } vec_t;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs[$];
  vec_t v;

  rob_issue_queue_buffer_if #(.DATA_WIDTH(128), .ROB_ADDR_WIDTH(4), .DEPTH(4)) bus ();

  rob_issue_queue_buffer #(.DATA_WIDTH(128), .ROB_ADDR_WIDTH(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] dataOf(input logic [3:0] tag);
    return {4{28'hC0FFEE0, tag}};
  endfunction

  function automatic vec_t mk(input string n, input logic fl, input logic kv,
                              input logic [3:0] ka, input logic [3:0] rh,
                              input logic iv, input logic [3:0] it, input logic ordy,
                              input logic ev, input logic [3:0] et,
                              input logic [2:0] ec, input logic er);
    vec_t r;
    r.name = n;  r.flush = fl;  r.kill = kv;  r.killAddr = ka;  r.robHead = rh;
    r.inValid = iv;  r.inTag = it;  r.outReady = ordy;
    r.expValid = ev;  r.expTag = et;  r.expCount = ec;  r.expReady = er;
    return r;
  endfunction

  task automatic cmp(input string what, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    bus.flush         = s.flush;
    bus.kill_valid    = s.kill;
    bus.kill_rob_addr = s.killAddr;
    bus.rob_head      = s.robHead;
    bus.in_valid      = s.inValid;
    bus.in_rob_addr   = s.inTag;
    bus.in_data       = dataOf(s.inTag);
    bus.out_ready     = s.outReady;
  endtask

  task automatic checkOutput(input vec_t s);
    cmp({s.name, "/out_valid"}, 128'(bus.out_valid), 128'(s.expValid));
    cmp({s.name, "/count"},     128'(bus.count),     128'(s.expCount));
    cmp({s.name, "/in_ready"},  128'(bus.in_ready),  128'(s.expReady));
    if (s.expValid) begin
      cmp({s.name, "/out_rob_addr"}, 128'(bus.out_rob_addr), 128'(s.expTag));
      cmp({s.name, "/out_data"},     bus.out_data,           dataOf(s.expTag));
    end else begin
      cmp({s.name, "/out_data_empty"}, bus.out_data, 128'(0));
    end
  endtask

  initial begin
    // name             fl kv ka  rh  iv tag or   ev tag cnt rdy
    vecs.push_back(mk("t1_push1",     0, 0, 0,  0,  1, 1,  0,  1, 1,  1, 1));
    vecs.push_back(mk("t1_push2",     0, 0, 0,  0,  1, 2,  0,  1, 1,  2, 1));
    vecs.push_back(mk("t1_push3",     0, 0, 0,  0,  1, 3,  0,  1, 1,  3, 1));
    vecs.push_back(mk("t2_flush",     1, 0, 0,  0,  0, 0,  0,  0, 0,  0, 1));
    vecs.push_back(mk("t2_push5",     0, 0, 0,  0,  1, 5,  0,  1, 5,  1, 1));
    vecs.push_back(mk("t2_push6",     0, 0, 0,  0,  1, 6,  0,  1, 5,  2, 1));
    vecs.push_back(mk("t2_push7",     0, 0, 0,  0,  1, 7,  0,  1, 5,  3, 1));
    vecs.push_back(mk("t2_push8",     0, 0, 0,  0,  1, 8,  0,  1, 5,  4, 0));
    vecs.push_back(mk("t2_popFull",   0, 0, 0,  0,  1, 9,  1,  1, 6,  3, 1));
    vecs.push_back(mk("t3_flush",     1, 0, 0,  0,  0, 0,  0,  0, 0,  0, 1));
    vecs.push_back(mk("t3_push2",     0, 0, 0,  2,  1, 2,  0,  1, 2,  1, 1));
    vecs.push_back(mk("t3_push3",     0, 0, 0,  2,  1, 3,  0,  1, 2,  2, 1));
    vecs.push_back(mk("t3_push4",     0, 0, 0,  2,  1, 4,  0,  1, 2,  3, 1));
    vecs.push_back(mk("t3_push5",     0, 0, 0,  2,  1, 5,  0,  1, 2,  4, 0));
    vecs.push_back(mk("t3_kill",      0, 1, 3,  2,  1, 6,  0,  1, 2,  2, 1));
    vecs.push_back(mk("t3_pop2",      0, 0, 0,  2,  0, 0,  1,  1, 3,  1, 1));
    vecs.push_back(mk("t3_pop3",      0, 0, 0,  2,  0, 0,  1,  0, 0,  0, 1));
    vecs.push_back(mk("t4_push14",    0, 0, 0, 14,  1, 14, 0,  1, 14, 1, 1));
    vecs.push_back(mk("t4_push15",    0, 0, 0, 14,  1, 15, 0,  1, 14, 2, 1));
    vecs.push_back(mk("t4_push0",     0, 0, 0, 14,  1, 0,  0,  1, 14, 3, 1));
    vecs.push_back(mk("t4_push1",     0, 0, 0, 14,  1, 1,  0,  1, 14, 4, 0));
    vecs.push_back(mk("t4_kill",      0, 1, 15, 14, 1, 2,  0,  1, 14, 2, 1));
    vecs.push_back(mk("t4_pop14",     0, 0, 0, 14,  0, 0,  1,  1, 15, 1, 1));
    vecs.push_back(mk("t4_pop15",     0, 0, 0, 14,  0, 0,  1,  0, 0,  0, 1));
    vecs.push_back(mk("k_push14",     0, 0, 0, 14,  1, 14, 0,  1, 14, 1, 1));
    vecs.push_back(mk("k_push15",     0, 0, 0, 14,  1, 15, 0,  1, 14, 2, 1));
    vecs.push_back(mk("k_push0",      0, 0, 0, 14,  1, 0,  0,  1, 14, 3, 1));
    vecs.push_back(mk("k_killDrop",   0, 1, 15, 14, 1, 2,  0,  1, 14, 2, 1));
    vecs.push_back(mk("k_killKeep",   0, 1, 0, 14,  1, 0,  0,  1, 14, 3, 1));
    vecs.push_back(mk("k_killPop",    0, 1, 15, 14, 0, 0,  1,  1, 15, 1, 1));
    vecs.push_back(mk("k_popLast",    0, 0, 0, 14,  0, 0,  1,  0, 0,  0, 1));
    vecs.push_back(mk("b_killEmpty",  0, 1, 5,  0,  0, 0,  0,  0, 0,  0, 1));
    vecs.push_back(mk("b_push4",      0, 0, 0,  0,  1, 4,  0,  1, 4,  1, 1));
    vecs.push_back(mk("b_push5",      0, 0, 0,  0,  1, 5,  0,  1, 4,  2, 1));
    vecs.push_back(mk("b_killOlder",  0, 1, 3,  0,  0, 0,  0,  0, 0,  0, 1));
    vecs.push_back(mk("b_popEmpty",   0, 0, 0,  0,  0, 0,  1,  0, 0,  0, 1));
    vecs.push_back(mk("t5_push1",     0, 0, 0,  0,  1, 1,  0,  1, 1,  1, 1));
    vecs.push_back(mk("t5_push2",     0, 0, 0,  0,  1, 2,  0,  1, 1,  2, 1));
    vecs.push_back(mk("t5_push3",     0, 0, 0,  0,  1, 3,  0,  1, 1,  3, 1));
    vecs.push_back(mk("t5_flushAll",  1, 1, 3,  0,  1, 4,  1,  0, 0,  0, 1));
    vecs.push_back(mk("t5_push9",     0, 0, 0,  0,  1, 9,  0,  1, 9,  1, 1));
    vecs.push_back(mk("t5_pop9",      0, 0, 0,  0,  0, 0,  1,  0, 0,  0, 1));

    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    cmp("reset/out_valid",    128'(bus.out_valid),    128'(0));
    cmp("reset/in_ready",     128'(bus.in_ready),     128'(1));
    cmp("reset/count",        128'(bus.count),        128'(0));
    cmp("reset/out_rob_addr", 128'(bus.out_rob_addr), 128'(0));
    cmp("reset/out_data",     bus.out_data,           128'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i]);
    end

    // Nothing may reach the output before the capturing edge.
    v = mk("lat_push12", 0, 0, 0, 0, 1, 12, 0, 1, 12, 1, 1);
    applyStimulus(v);
    #1 cmp("lat_push12/no_comb_path", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1 checkOutput(v);
    v = mk("rst_push13", 0, 0, 0, 0, 1, 13, 0, 1, 12, 2, 1);
    applyStimulus(v);
    @(posedge clk);
    #1 checkOutput(v);

    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #2 rst = 1'b1;
    #1;
    cmp("asyncRst/out_valid", 128'(bus.out_valid), 128'(0));
    cmp("asyncRst/count",     128'(bus.count),     128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    cmp("postRst/count",    128'(bus.count),    128'(0));
    cmp("postRst/in_ready", 128'(bus.in_ready), 128'(1));
    v = mk("postRst_push14", 0, 0, 0, 0, 1, 14, 0, 1, 14, 1, 1);
    applyStimulus(v);
    @(posedge clk);
    #1 checkOutput(v);
    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
